// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared constants and helpers for the reorder buffer of the OoO 6502 core.
//   PR_ADDR_W     : physical register index width (6 aliases x 5 bits = 30-bit
//                   freed-register bus)
//   ROB_DEPTH     : entry count, power of two
//   ROB_ADDR_W    : log2(ROB_DEPTH)
//   ALLOC_W       : allocation lanes per cycle
//   CMPL_W        : completion ports per cycle
//   ROB_RET_W     : retire lanes per cycle (each frees two aliases)
// No ports (package).
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int PR_ADDR_W   = 5;
  localparam int ROB_DEPTH   = 32;
  localparam int ROB_ADDR_W  = 5;
  localparam int ALLOC_W     = 4;
  localparam int CMPL_W      = 3;
  localparam int ROB_RET_W   = 3;

  // Widths of the small lane counters (0..ALLOC_W and 0..ROB_RET_W).
  localparam int ALLOC_CNT_W = 3;
  localparam int RET_CNT_W   = 2;

  // Physical registers at or below this index are architectural constants
  // and must never be handed back to the free pool.
  localparam logic [PR_ADDR_W-1:0] LAST_RESERVED_PR = PR_ADDR_W'(1);

  typedef logic [ROB_ADDR_W-1:0] robIdx_t;

  // Number of consecutive ones starting at bit 0; claims beyond the first
  // gap are not honoured by the buffer.
  function automatic logic [ALLOC_CNT_W-1:0] leadingOnes(input logic [ALLOC_W-1:0] v);
    logic [ALLOC_CNT_W-1:0] n;
    logic                   run;
    n   = '0;
    run = 1'b1;
    for (int k = 0; k < ALLOC_W; k++) begin
      run = run & v[k];
      if (run) n = n + ALLOC_CNT_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/reorder_buffer_retire_select.sv
// -----------------------------------------------------------------------------
// rob_retire_select
// Picks the oldest run of valid && done entries starting at head, at most
// ROB_RET_W long. Purely combinational.
//   i_head      : current head index
//   i_valid     : per-entry valid bits
//   i_done      : per-entry done bits
//   o_retCount  : number of entries to retire (0..ROB_RET_W)
//   o_retIdx    : lane i = (head + i) mod ROB_DEPTH, meaningful for i < count
// -----------------------------------------------------------------------------
module rob_retire_select
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_ADDR_W-1:0]           i_head,
  input  logic [ROB_DEPTH-1:0]            i_valid,
  input  logic [ROB_DEPTH-1:0]            i_done,
  output logic [RET_CNT_W-1:0]            o_retCount,
  output logic [ROB_RET_W*ROB_ADDR_W-1:0] o_retIdx
);

  logic w_run;

  // Walk forward from head; the first entry that is not both valid and done
  // stops retirement for this cycle so younger work never retires early.
  always_comb begin
    o_retCount = '0;
    o_retIdx   = '0;
    w_run      = 1'b1;
    for (int i = 0; i < ROB_RET_W; i++) begin
      o_retIdx[i*ROB_ADDR_W +: ROB_ADDR_W] = i_head + ROB_ADDR_W'(i);
      w_run = w_run & i_valid[o_retIdx[i*ROB_ADDR_W +: ROB_ADDR_W]]
                    & i_done[o_retIdx[i*ROB_ADDR_W +: ROB_ADDR_W]];
      if (w_run) o_retCount = o_retCount + RET_CNT_W'(1);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// In-order retirement end of the rename pipeline. Hands free entries to the
// renamer, records displaced physical aliases, marks entries done on
// completion and retires up to ROB_RET_W oldest done entries per cycle,
// returning their aliases on the freed-register bus.
//   clk, rst            : clock, synchronous active-high reset
//   alloc_entries       : lane k = (tail + k) mod ROB_DEPTH
//   alloc_count         : lanes allocatable this cycle, min(4, free space)
//   alloc_valid         : renamer lane claims, honoured contiguously from lane 0
//   alloc_old_aliases   : per lane two displaced physical regs (0 = none)
//   cmplt_valid/_rob    : completion strobes and their ROB indices
//   free_regs/_valid    : registered freed regs, slot 2i/2i+1 = retire lane i
//   rob_count/rob_empty : occupancy and empty flag
// -----------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  output logic [ALLOC_W*ROB_ADDR_W-1:0]     alloc_entries,
  output logic [2:0]                        alloc_count,
  input  logic [ALLOC_W-1:0]                alloc_valid,
  input  logic [ALLOC_W*2*PR_ADDR_W-1:0]    alloc_old_aliases,
  input  logic [CMPL_W-1:0]                 cmplt_valid,
  input  logic [CMPL_W*ROB_ADDR_W-1:0]      cmplt_rob,
  output logic [ROB_RET_W*2*PR_ADDR_W-1:0]  free_regs,
  output logic [ROB_RET_W*2-1:0]            free_regs_valid,
  output logic [ROB_ADDR_W:0]               rob_count,
  output logic                              rob_empty
);

  localparam logic [ROB_ADDR_W:0] DEPTH = (ROB_ADDR_W+1)'(ROB_DEPTH);

  robIdx_t                          r_head;
  robIdx_t                          r_tail;
  logic [ROB_ADDR_W:0]              r_count;
  logic [ROB_DEPTH-1:0]             r_valid;
  logic [ROB_DEPTH-1:0]             r_done;
  logic [2*PR_ADDR_W-1:0]           r_oldAliases [ROB_DEPTH];
  logic [ROB_RET_W*2*PR_ADDR_W-1:0] r_freeRegs;
  logic [ROB_RET_W*2-1:0]           r_freeValid;

  logic [ROB_ADDR_W:0]              w_space;
  logic [ALLOC_CNT_W-1:0]           w_allocCount;
  logic [ALLOC_CNT_W-1:0]           w_leadOnes;
  logic [ALLOC_CNT_W-1:0]           w_accepted;
  logic [RET_CNT_W-1:0]             w_retCount;
  logic [ROB_RET_W*ROB_ADDR_W-1:0]  w_retIdx;
  logic [ROB_DEPTH-1:0]             w_validNext;
  logic [ROB_DEPTH-1:0]             w_doneNext;
  logic [ROB_RET_W*2*PR_ADDR_W-1:0] w_freeRegs;
  logic [ROB_RET_W*2-1:0]           w_freeValid;

  rob_retire_select u_retireSelect (
    .i_head     (r_head),
    .i_valid    (r_valid),
    .i_done     (r_done),
    .o_retCount (w_retCount),
    .o_retIdx   (w_retIdx)
  );

  // Allocation capacity uses the pre-retire count, so slots freed this edge
  // only become allocatable next cycle and allocation can never overrun.
  always_comb begin
    w_space      = DEPTH - r_count;
    w_allocCount = (w_space >= (ROB_ADDR_W+1)'(ALLOC_W)) ? ALLOC_CNT_W'(ALLOC_W)
                                                        : w_space[ALLOC_CNT_W-1:0];
    w_leadOnes   = leadingOnes(alloc_valid);
    w_accepted   = (w_leadOnes > w_allocCount) ? w_allocCount : w_leadOnes;
    for (int k = 0; k < ALLOC_W; k++) begin
      alloc_entries[k*ROB_ADDR_W +: ROB_ADDR_W] = r_tail + ROB_ADDR_W'(k);
    end
  end

  assign alloc_count = w_allocCount;

  // Next valid/done vectors. Completion only hits entries valid before the
  // edge, so a completion aimed at a lane being allocated now is dropped;
  // allocation is applied last and forces done low for its own entries.
  always_comb begin
    w_validNext = r_valid;
    w_doneNext  = r_done;
    for (int p = 0; p < CMPL_W; p++) begin
      if (cmplt_valid[p] && r_valid[cmplt_rob[p*ROB_ADDR_W +: ROB_ADDR_W]]) begin
        w_doneNext[cmplt_rob[p*ROB_ADDR_W +: ROB_ADDR_W]] = 1'b1;
      end
    end
    for (int i = 0; i < ROB_RET_W; i++) begin
      if (i < int'(w_retCount)) begin
        w_validNext[w_retIdx[i*ROB_ADDR_W +: ROB_ADDR_W]] = 1'b0;
        w_doneNext[w_retIdx[i*ROB_ADDR_W +: ROB_ADDR_W]]  = 1'b0;
      end
    end
    for (int k = 0; k < ALLOC_W; k++) begin
      if (k < int'(w_accepted)) begin
        w_validNext[r_tail + ROB_ADDR_W'(k)] = 1'b1;
        w_doneNext[r_tail + ROB_ADDR_W'(k)]  = 1'b0;
      end
    end
  end

  // Freed-register bus: reserved regs 0/1 and unused lanes read as zero so
  // the renamer can trust the value even without looking at valid.
  always_comb begin
    w_freeRegs  = '0;
    w_freeValid = '0;
    for (int i = 0; i < ROB_RET_W; i++) begin
      for (int j = 0; j < 2; j++) begin
        if ((i < int'(w_retCount)) &&
            (r_oldAliases[w_retIdx[i*ROB_ADDR_W +: ROB_ADDR_W]][j*PR_ADDR_W +: PR_ADDR_W]
              > LAST_RESERVED_PR)) begin
          w_freeValid[2*i+j] = 1'b1;
          w_freeRegs[(2*i+j)*PR_ADDR_W +: PR_ADDR_W] =
            r_oldAliases[w_retIdx[i*ROB_ADDR_W +: ROB_ADDR_W]][j*PR_ADDR_W +: PR_ADDR_W];
        end
      end
    end
  end

  // Control state and registered outputs; reset discards in-flight work
  // without freeing anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_valid     <= '0;
      r_done      <= '0;
      r_freeRegs  <= '0;
      r_freeValid <= '0;
    end else begin
      r_head      <= r_head + ROB_ADDR_W'(w_retCount);
      r_tail      <= r_tail + ROB_ADDR_W'(w_accepted);
      r_count     <= r_count + (ROB_ADDR_W+1)'(w_accepted) - (ROB_ADDR_W+1)'(w_retCount);
      r_valid     <= w_validNext;
      r_done      <= w_doneNext;
      r_freeRegs  <= w_freeRegs;
      r_freeValid <= w_freeValid;
    end
  end

  // Alias payload storage; contents are meaningless while an entry is
  // invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ALLOC_W; k++) begin
      if (!rst && (k < int'(w_accepted))) begin
        r_oldAliases[r_tail + ROB_ADDR_W'(k)] <= alloc_old_aliases[k*2*PR_ADDR_W +: 2*PR_ADDR_W];
      end
    end
  end

  assign free_regs       = r_freeRegs;
  assign free_regs_valid = r_freeValid;
  assign rob_count       = r_count;
  assign rob_empty       = (r_count == '0);

endmodule
